pucch_occ_seq: RTL

- Generates the full per-symbol time-domain OCC phase stream for PUCCH format 1 over one PUCCH allocation.
- Covers both DMRS (even l) and UCI data (odd l) symbols, with or without intra-slot frequency hopping.
- Derives nSF per (type, hop) from nPUCCHSym and emits one phase per symbol on a valid/ready stream.
- Sits between the PUCCH config registers and the format-1 symbol mapper; replaces single-hop, data-only phase stepping.

---
 rtl/pucch_pkg.sv | 50 +++++
 rtl/pucch_occ_phi_gen.sv | 49 ++++
 rtl/pucch_occ_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pucch_pkg.sv
// Shared types and constants for the PUCCH format-1 OCC phase sequencer.
package pucch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] N_SYM_MIN = 4'd4;
  localparam logic [3:0] N_SYM_MAX = 4'd14;
  localparam logic [2:0] NSF_MAX   = 3'd7;

  // nSF == 4 phase table, indexed [occi[1:0]][m[1:0]], phases 0 or 2
  localparam logic [0:3][0:3][1:0] NSF4_LUT = '{
    '{2'd0, 2'd0, 2'd0, 2'd0},
    '{2'd0, 2'd2, 2'd0, 2'd2},
    '{2'd0, 2'd0, 2'd2, 2'd2},
    '{2'd0, 2'd2, 2'd2, 2'd0}
  };

  typedef struct packed {
    logic [3:0] h0;   // symbols in hop 0
    logic [2:0] d0;   // DMRS count, hop 0
    logic [2:0] u0;   // data count, hop 0
    logic [2:0] d1;   // DMRS count, hop 1
    logic [2:0] u1;   // data count, hop 1
  } nsf_split_t;

  // Per-(type, hop) symbol counts; each count is the nSF of that group
  function automatic nsf_split_t nsf_split(input logic [3:0] n, input logic hop_en);
    logic [4:0] h0;
    logic [4:0] d0;
    logic [4:0] u0;
    logic [4:0] dt;
    logic [4:0] ut;
    nsf_split_t s;
    h0   = hop_en ? {2'b00, n[3:1]} : {1'b0, n};
    d0   = (h0 + 5'd1) >> 1;
    u0   = h0 >> 1;
    dt   = ({1'b0, n} + 5'd1) >> 1;
    ut   = {1'b0, n} >> 1;
    s.h0 = h0[3:0];
    s.d0 = d0[2:0];
    s.u0 = u0[2:0];
    s.d1 = 3'(dt - d0);
    s.u1 = 3'(ut - u0);
    return s;
  endfunction

endpackage

// File: rtl/pucch_occ_phi_gen.sv
// OCC phase generator for one symbol type: m counter, mod-nSF accumulator, nSF=4 LUT.
module pucch_occ_phi_gen
  import pucch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_step,
  input  logic [2:0] i_nsf,
  input  logic [2:0] i_occi,
  output logic [3:0] o_phi,
  output logic [2:0] o_m
);

  logic [3:0] r_acc;
  logic [2:0] r_m;
  logic [3:0] w_sum;
  logic [3:0] w_acc_nx;

  // Next phase: add occi, single conditional subtract of nSF
  always_comb begin
    w_sum    = r_acc + {1'b0, i_occi};
    w_acc_nx = (w_sum >= {1'b0, i_nsf}) ? (w_sum - {1'b0, i_nsf}) : w_sum;
  end

  // Accumulator and m counter; clear wins over step
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
      r_m   <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_nx;
      r_m   <= r_m + 3'd1;
    end
  end

  // Phase select: LUT for nSF=4, zero for nSF=1, accumulator otherwise
  always_comb begin
    if (i_nsf == 3'd4)
      o_phi = {2'b00, NSF4_LUT[i_occi[1:0]][r_m[1:0]]};
    else if (i_nsf == 3'd1)
      o_phi = '0;
    else
      o_phi = r_acc;
  end

  assign o_m = r_m;

endmodule

// File: rtl/pucch_occ_seq.sv
// PUCCH format-1 per-symbol OCC phase sequencer (DMRS + data, optional hopping).
// Optional config rejection when PUCCH_OCC_CFG_CHECK_EN is defined.
module pucch_occ_seq
  import pucch_pkg::*;
#(
  parameter int unsigned SYM_W     = 4,
  parameter int unsigned PHI_W     = 4,
  parameter int unsigned DMRS_EVEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [SYM_W-1:0] i_n_sym,
  input  logic             i_hop_en,
  input  logic [2:0]       i_occi,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PHI_W-1:0] o_phi,
  output logic [2:0]       o_nsf,
  output logic             o_is_dmrs,
  output logic             o_hop,
  output logic [2:0]       o_m,
  output logic [SYM_W-1:0] o_l,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_err
);

  state_t           r_state;
  state_t           w_state_nx;
  logic [SYM_W-1:0] r_l;
  logic [SYM_W-1:0] r_n;
  logic [2:0]       r_occi;
  nsf_split_t       r_split;

  logic             w_run;
  logic             w_hs;
  logic             w_last_l;
  logic             w_is_dmrs;
  logic             w_hop;
  logic             w_cfg_ok;
  logic             w_start_ok;
  logic             w_advance;
  logic             w_clr;
  logic [2:0]       w_nsf_dmrs;
  logic [2:0]       w_nsf_data;
  logic [3:0]       w_phi_dmrs;
  logic [3:0]       w_phi_data;
  logic [2:0]       w_m_dmrs;
  logic [2:0]       w_m_data;

`ifdef PUCCH_OCC_CFG_CHECK_EN
  nsf_split_t w_in_split;
  logic [2:0] w_min_nsf;
  logic       r_err;

  // Reject out-of-range N or an occi not below the smallest non-empty nSF
  always_comb begin
    w_in_split = nsf_split(4'(i_n_sym), i_hop_en);
    w_min_nsf  = NSF_MAX;
    if (w_in_split.d0 != 3'd0 && w_in_split.d0 < w_min_nsf) w_min_nsf = w_in_split.d0;
    if (w_in_split.u0 != 3'd0 && w_in_split.u0 < w_min_nsf) w_min_nsf = w_in_split.u0;
    if (w_in_split.d1 != 3'd0 && w_in_split.d1 < w_min_nsf) w_min_nsf = w_in_split.d1;
    if (w_in_split.u1 != 3'd0 && w_in_split.u1 < w_min_nsf) w_min_nsf = w_in_split.u1;
    w_cfg_ok = (4'(i_n_sym) >= N_SYM_MIN) && (4'(i_n_sym) <= N_SYM_MAX) &&
               (i_occi < w_min_nsf);
  end

  // One-cycle reject pulse following the offending i_start
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= i_start && !w_cfg_ok;
  end

  assign o_err = r_err;
`else
  assign w_cfg_ok = 1'b1;
  assign o_err    = 1'b0;
`endif

  // Current-symbol decode
  always_comb begin
    w_run      = (r_state == RUN);
    w_hs       = w_run && i_ready;
    w_last_l   = (r_l == SYM_W'(r_n - 1'b1));
    w_is_dmrs  = (DMRS_EVEN != 0) ? ~r_l[0] : r_l[0];
    w_hop      = (r_l >= SYM_W'(r_split.h0));
    w_nsf_dmrs = w_hop ? r_split.d1 : r_split.d0;
    w_nsf_data = w_hop ? r_split.u1 : r_split.u0;
    w_start_ok = i_start && w_cfg_ok;
    w_advance  = w_hs && !w_last_l && !i_start;
    // Both generators restart at l=0 and when stepping onto the first hop-1 symbol
    w_clr      = w_start_ok || (w_advance && (SYM_W'(r_l + 1'b1) == SYM_W'(r_split.h0)));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // FSM next state: i_start has priority over the final handshake
  always_comb begin
    w_state_nx = r_state;
    if (i_start)
      w_state_nx = w_cfg_ok ? RUN : IDLE;
    else if (w_hs && w_last_l)
      w_state_nx = IDLE;
  end

  // Config capture and symbol index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_l     <= '0;
      r_n     <= '0;
      r_occi  <= '0;
      r_split <= '0;
    end else if (w_start_ok) begin
      r_l     <= '0;
      r_n     <= i_n_sym;
      r_occi  <= i_occi;
      r_split <= nsf_split(4'(i_n_sym), i_hop_en);
    end else if (w_advance) begin
      r_l     <= r_l + 1'b1;
    end
  end

  pucch_occ_phi_gen u_dmrs (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_clr),
    .i_step (w_advance && w_is_dmrs),
    .i_nsf  (w_nsf_dmrs),
    .i_occi (r_occi),
    .o_phi  (w_phi_dmrs),
    .o_m    (w_m_dmrs)
  );

  pucch_occ_phi_gen u_data (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_clr),
    .i_step (w_advance && !w_is_dmrs),
    .i_nsf  (w_nsf_data),
    .i_occi (r_occi),
    .o_phi  (w_phi_data),
    .o_m    (w_m_data)
  );

  // Beat outputs, forced to zero outside RUN
  always_comb begin
    o_valid   = w_run;
    o_busy    = w_run;
    o_phi     = '0;
    o_nsf     = '0;
    o_is_dmrs = 1'b0;
    o_hop     = 1'b0;
    o_m       = '0;
    o_l       = '0;
    o_last    = 1'b0;
    if (w_run) begin
      o_phi     = PHI_W'(w_is_dmrs ? w_phi_dmrs : w_phi_data);
      o_nsf     = w_is_dmrs ? w_nsf_dmrs : w_nsf_data;
      o_is_dmrs = w_is_dmrs;
      o_hop     = w_hop;
      o_m       = w_is_dmrs ? w_m_dmrs : w_m_data;
      o_l       = r_l;
      o_last    = w_last_l;
    end
  end

endmodule
